// File: rtl/adaptive_filter_pkg.sv
// rtl/adaptive_filter_pkg.sv - shared constants and types for the adaptive filter output path
// Contents:
//   FILTER_ORDER      delay-line depth of the adaptive filter
//   SAMPLE_W          native filter sample width
//   DEF_BLANK_CYCLES  settling samples to discard, equal to the delay-line depth
//   out_state_e       output-stage FSM states
//   fifo_word_t       output FIFO entry {mode, data}
package adaptive_filter_pkg;

    localparam int FILTER_ORDER     = 6;
    localparam int SAMPLE_W         = 14;
    localparam int DEF_BLANK_CYCLES = FILTER_ORDER;

    typedef enum logic {
        BLANK = 1'b0,
        RUN   = 1'b1
    } out_state_e;

    typedef struct packed {
        logic                mode;
        logic [SAMPLE_W-1:0] data;
    } fifo_word_t;

endpackage

// File: rtl/filter_out_fifo.sv
// rtl/filter_out_fifo.sv - generic synchronous first-word-fall-through FIFO
// Ports:
//   clk_i, arst_ni   clock, asynchronous active-low reset
//   push_i, wdata_i  write request and data (ignored when full unless popping)
//   pop_i            read request (ignored when empty)
//   rdata_o          head entry, valid whenever empty_o is low
//   full_o, empty_o  occupancy flags
module filter_out_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot the push lands in, so full+pop still accepts.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign rdata_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/filter_out_stream.sv
// rtl/filter_out_stream.sv - filter output stage: settling blanking, boxcar decimation, FIFO
// Ports:
//   clk, arst_n        clock, asynchronous active-low reset
//   ctrl               filter mode (1 integrator, 0 differentiator)
//   s_tdata            free-running filter samples, one per clock
//   dec_log2           decimation ratio 2^dec_log2, latched per window
//   m_tdata/m_tuser    output sample and the mode that produced it
//   m_tvalid/m_tready  output handshake
//   overflow, ovf_clr  sticky drop flag and its clear
module filter_out_stream
    import adaptive_filter_pkg::*;
#(
    parameter int DATA_W       = SAMPLE_W,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              ctrl,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [1:0]        dec_log2,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tuser,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int ACC_W = DATA_W + 3;
    localparam int CNT_W = $clog2(BLANK_CYCLES + 1);

    out_state_e                state_q, state_d;
    logic [CNT_W-1:0]          blank_cnt_q, blank_cnt_d;
    logic                      ctrl_q;
    logic [2:0]                phase_q, phase_d;
    logic [1:0]                dec_q, dec_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]         res_q, res_d;
    logic                      res_mode_q, res_mode_d;
    logic                      res_vld_q, res_vld_d;
    logic                      ovf_q, ovf_d;

    logic                      ctrl_chg;
    logic                      run_en;
    logic [1:0]                eff_dec;
    logic                      win_last;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   avg;
    logic [DATA_W:0]           fifo_rdata;
    logic                      fifo_full, fifo_empty, fifo_pop, drop;

    assign ctrl_chg = (ctrl != ctrl_q);

    // FSM: state register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= BLANK;
            blank_cnt_q <= CNT_W'(BLANK_CYCLES);
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    // FSM: next state; any mode change restarts the settling period
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        if (ctrl_chg) begin
            state_d     = BLANK;
            blank_cnt_d = CNT_W'(BLANK_CYCLES);
        end else if (state_q == BLANK) begin
            blank_cnt_d = blank_cnt_q - 1'b1;
            if (blank_cnt_q == CNT_W'(1)) begin
                state_d = RUN;
            end
        end
    end

    // FSM: outputs; the sample of a ctrl-change cycle is never used
    always_comb begin
        run_en = (state_q == RUN) && !ctrl_chg;
    end

    // Decimator: the ratio is sampled at phase 0 so a window never changes length
    assign eff_dec  = (phase_q == 3'd0) ? dec_log2 : dec_q;
    assign win_last = ({1'b0, phase_q} == ((4'd1 << eff_dec) - 4'd1));
    assign sum      = acc_q + ACC_W'($signed(s_tdata));
    assign avg      = sum >>> eff_dec;

    always_comb begin
        acc_d      = acc_q;
        phase_d    = phase_q;
        dec_d      = dec_q;
        res_d      = res_q;
        res_mode_d = res_mode_q;
        res_vld_d  = 1'b0;
        if (!run_en) begin
            acc_d   = '0;
            phase_d = '0;
        end else begin
            dec_d = eff_dec;
            if (win_last) begin
                acc_d      = '0;
                phase_d    = '0;
                res_d      = avg[DATA_W-1:0];
                res_mode_d = ctrl_q;
                res_vld_d  = 1'b1;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + 3'd1;
            end
        end
    end

    // Overflow: a drop in the same cycle as a clear wins
    assign fifo_pop = m_tvalid && m_tready;
    assign drop     = res_vld_q && fifo_full && !fifo_pop;
    assign ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ctrl_q     <= 1'b0;
            phase_q    <= '0;
            dec_q      <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            res_mode_q <= 1'b0;
            res_vld_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl;
            phase_q    <= phase_d;
            dec_q      <= dec_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            res_mode_q <= res_mode_d;
            res_vld_q  <= res_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    filter_out_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .arst_ni (arst_n),
        .push_i  (res_vld_q),
        .wdata_i ({res_mode_q, res_q}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // FIFO storage is not reset, so the head is masked while empty.
    assign m_tvalid = !fifo_empty;
    assign m_tdata  = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
    assign m_tuser  = !fifo_empty && fifo_rdata[DATA_W];
    assign overflow = ovf_q;

endmodule

// File: tb/tb_filter_out_stream.sv
// tb/tb_filter_out_stream.sv - self-checking bench for filter_out_stream
module tb_filter_out_stream;

    localparam int DW = 14;
    localparam int BC = 6;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          ctrl = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [1:0]    dec_log2 = 2'd0;
    logic          m_tready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tuser;
    logic          m_tvalid;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    filter_out_stream #(.DATA_W(DW), .BLANK_CYCLES(BC), .FIFO_DEPTH(FD)) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .ctrl     (ctrl),
        .s_tdata  (s_tdata),
        .dec_log2 (dec_log2),
        .m_tdata  (m_tdata),
        .m_tuser  (m_tuser),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: sample-level behaviour with a queue for the FIFO
    typedef struct { int data; bit mode; } word_t;
    word_t mq[$];
    int    win[$];
    int    m_blank;
    bit    m_prev;
    int    m_dec;
    bit    m_pend;
    word_t m_res;
    bit    m_ovf;

    function automatic void model_reset();
        mq.delete();
        win.delete();
        m_blank = BC;
        m_prev  = 1'b0;
        m_dec   = 0;
        m_pend  = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    function automatic int floor_div(int a, int n);
        int r;
        r = a % n;
        if (r < 0) r += n;
        return (a - r) / n;
    endfunction

    // Advances the model by one clock using the inputs currently applied.
    function automatic void model_step();
        bit full, pop, dropped;
        int sum, n;
        full    = (mq.size() == FD);
        pop     = (mq.size() != 0) && m_tready;
        dropped = m_pend && full && !pop;
        if (pop) void'(mq.pop_front());
        if (m_pend && !dropped) mq.push_back(m_res);
        if (dropped) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_pend = 1'b0;
        if (ctrl != m_prev) begin
            m_blank = BC;
            win.delete();
        end else if (m_blank > 0) begin
            m_blank--;
        end else begin
            if (win.size() == 0) m_dec = int'(dec_log2);
            win.push_back(int'($signed(s_tdata)));
            n = 1 << m_dec;
            if (win.size() == n) begin
                sum = 0;
                foreach (win[k]) sum += win[k];
                m_res.data = floor_div(sum, n);
                m_res.mode = ctrl;
                m_pend = 1'b1;
                win.delete();
            end
        end
        m_prev = ctrl;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        arst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        hold_reset();
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
        checks++; if (m_tuser !== 1'b0) begin failures++; $display("FAIL reset_tuser got=%b exp=0", m_tuser); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_ramp();
        int first_cyc = -1;
        int first_data = -1;
        bit first_mode = 1'b1;
        int vcnt = 0;
        hold_reset();
        ctrl = 1'b0; dec_log2 = 2'd0; m_tready = 1'b1; ovf_clr = 1'b0;
        arst_n = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            s_tdata = DW'(cyc);
            if (m_tvalid === 1'b1) begin
                vcnt++;
                if (first_cyc < 0) begin
                    first_cyc = cyc; first_data = int'($signed(m_tdata)); first_mode = m_tuser;
                end
            end
            checks++;
            if (m_tvalid !== (mq.size() != 0)) begin
                failures++; $display("FAIL ramp_valid cyc=%0d got=%b exp=%b", cyc, m_tvalid, mq.size() != 0);
            end else if (mq.size() != 0) begin
                checks++;
                if (int'($signed(m_tdata)) != mq[0].data || m_tuser !== mq[0].mode) begin
                    failures++; $display("FAIL ramp_word cyc=%0d got=%0d/%b exp=%0d/%b", cyc, $signed(m_tdata), m_tuser, mq[0].data, mq[0].mode);
                end
            end
            tick();
        end
        checks++; if (first_cyc != 8) begin failures++; $display("FAIL ramp_first_cycle got=%0d exp=8", first_cyc); end
        checks++; if (first_data != 6 || first_mode !== 1'b0) begin failures++; $display("FAIL ramp_first_word got=%0d/%b exp=6/0", first_data, first_mode); end
        checks++; if (vcnt != 22) begin failures++; $display("FAIL ramp_rate got=%0d exp=22", vcnt); end
    endtask

    task automatic test_decim();
        int vec[16] = '{1, 2, 3, 4, -1, -2, -3, -4, 8191, 8191, 8191, 8191, -8192, -8192, -8192, -8192};
        int exp_w[4] = '{2, -3, 8191, -8192};
        int got[$];
        // Continues the dec_log2=0 stream of test_ramp, so phase is 0 here.
        for (int i = 0; i < 20; i++) begin
            dec_log2 = 2'd2;
            s_tdata  = (i < 16) ? DW'(vec[i]) : '0;
            if (i >= 2 && m_tvalid === 1'b1 && m_tready) got.push_back(int'($signed(m_tdata)));
            checks++;
            if (m_tvalid !== (mq.size() != 0)) begin
                failures++; $display("FAIL decim_valid i=%0d got=%b exp=%b", i, m_tvalid, mq.size() != 0);
            end
            tick();
        end
        checks++;
        if (got.size() != 4) begin
            failures++; $display("FAIL decim_count got=%0d exp=4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got[k] != exp_w[k]) begin failures++; $display("FAIL decim_word%0d got=%0d exp=%0d", k, got[k], exp_w[k]); end
            end
        end
    endtask

    task automatic test_ctrl_change();
        int gd[$];
        bit gm[$];
        int sv;
        hold_reset();
        ctrl = 1'b0; dec_log2 = 2'd2; m_tready = 1'b1; ovf_clr = 1'b0;
        arst_n = 1'b1;
        for (int cyc = 0; cyc < 26; cyc++) begin
            if (cyc >= 6 && cyc <= 9) sv = 1;
            else if (cyc == 10 || cyc == 11) sv = 50;
            else if (cyc == 19) sv = 10;
            else if (cyc == 20) sv = 20;
            else if (cyc == 21) sv = 30;
            else if (cyc == 22) sv = 41;
            else sv = 999;
            s_tdata = DW'(sv);
            ctrl = (cyc >= 12);
            if (m_tvalid === 1'b1) begin gd.push_back(int'($signed(m_tdata))); gm.push_back(m_tuser); end
            checks++;
            if (m_tvalid !== (mq.size() != 0)) begin
                failures++; $display("FAIL ctrl_valid cyc=%0d got=%b exp=%b", cyc, m_tvalid, mq.size() != 0);
            end
            tick();
        end
        checks++;
        if (gd.size() != 2) begin
            failures++; $display("FAIL ctrl_count got=%0d exp=2", gd.size());
        end else begin
            checks++; if (gd[0] != 1 || gm[0] !== 1'b0) begin failures++; $display("FAIL ctrl_word0 got=%0d/%b exp=1/0", gd[0], gm[0]); end
            checks++; if (gd[1] != 25 || gm[1] !== 1'b1) begin failures++; $display("FAIL ctrl_word1 got=%0d/%b exp=25/1", gd[1], gm[1]); end
        end
    endtask

    task automatic test_overflow();
        int pops[$];
        int exp_p[10] = '{6, 7, 8, 9, 10, 11, 12, 13, 17, 18};
        hold_reset();
        ctrl = 1'b0; dec_log2 = 2'd0; m_tready = 1'b0; ovf_clr = 1'b0;
        arst_n = 1'b1;
        for (int cyc = 0; cyc < 34; cyc++) begin
            s_tdata  = DW'(cyc);
            ovf_clr  = (cyc == 16 || cyc == 18);
            m_tready = (cyc >= 18);
            if (cyc == 15) begin
                checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before_drop got=%b exp=0", overflow); end
            end
            if (cyc == 16 || cyc == 17) begin
                checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set cyc=%0d got=%b exp=1", cyc, overflow); end
            end
            if (cyc >= 19) begin
                checks++;
                if (overflow !== 1'b0 || m_tvalid !== 1'b1) begin
                    failures++; $display("FAIL ovf_full_pop cyc=%0d got=%b/%b exp=0/1", cyc, overflow, m_tvalid);
                end
            end
            if (m_tvalid === 1'b1 && m_tready) pops.push_back(int'($signed(m_tdata)));
            checks++;
            if (overflow !== m_ovf || m_tvalid !== (mq.size() != 0)) begin
                failures++; $display("FAIL ovf_model cyc=%0d got=%b/%b exp=%b/%b", cyc, overflow, m_tvalid, m_ovf, mq.size() != 0);
            end
            tick();
        end
        ovf_clr = 1'b0;
        checks++;
        if (pops.size() < 10) begin
            failures++; $display("FAIL ovf_drain_count got=%0d exp>=10", pops.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (pops[k] != exp_p[k]) begin failures++; $display("FAIL ovf_drain%0d got=%0d exp=%0d", k, pops[k], exp_p[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int first_cyc = -1;
        int first_data = -1;
        hold_reset();
        ctrl = 1'b0; dec_log2 = 2'd0; m_tready = 1'b0; ovf_clr = 1'b0;
        arst_n = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            s_tdata = DW'(cyc);
            tick();
        end
        checks++; if (m_tvalid !== 1'b1 || mq.size() != 5) begin failures++; $display("FAIL rst_mid_queued got=%b exp=1 (model %0d)", m_tvalid, mq.size()); end
        arst_n = 1'b0;
        #2;
        checks++; if (m_tvalid !== 1'b0 || m_tdata !== '0) begin failures++; $display("FAIL rst_mid_async got=%b/%h exp=0/0", m_tvalid, m_tdata); end
        hold_reset();
        m_tready = 1'b1;
        arst_n = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            s_tdata = DW'(100 + cyc);
            if (m_tvalid === 1'b1 && first_cyc < 0) begin first_cyc = cyc; first_data = int'($signed(m_tdata)); end
            tick();
        end
        checks++; if (first_cyc != 8 || first_data != 106) begin failures++; $display("FAIL rst_mid_reblank got=%0d@%0d exp=106@8", first_data, first_cyc); end
    endtask

    task automatic test_random();
        hold_reset();
        ctrl = 1'b0; dec_log2 = 2'd0; m_tready = 1'b1; ovf_clr = 1'b0;
        arst_n = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            s_tdata = DW'($urandom);
            if ($urandom_range(0, 39) == 0) ctrl = ~ctrl;
            if ($urandom_range(0, 9) == 0) dec_log2 = 2'($urandom_range(0, 3));
            m_tready = ($urandom_range(0, 9) < 7);
            ovf_clr  = ($urandom_range(0, 7) == 0);
            checks++;
            if (m_tvalid !== (mq.size() != 0) || overflow !== m_ovf) begin
                failures++; $display("FAIL rand_flags cyc=%0d got=%b/%b exp=%b/%b", cyc, m_tvalid, overflow, mq.size() != 0, m_ovf);
            end else if (mq.size() != 0) begin
                checks++;
                if (int'($signed(m_tdata)) != mq[0].data || m_tuser !== mq[0].mode) begin
                    failures++; $display("FAIL rand_word cyc=%0d got=%0d/%b exp=%0d/%b", cyc, $signed(m_tdata), m_tuser, mq[0].data, mq[0].mode);
                end
            end
            tick();
        end
        ovf_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_decim();
        test_ctrl_change();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/filter_out_stream.md
# filter_out_stream

Output stage directly downstream of the adaptive filter. Takes the filter's free-running 14-bit sample stream (one sample per clock), blanks the filter's settling transient after reset and after every integrator/differentiator mode change, and optionally decimates by 1/2/4/8 with boxcar averaging. It buffers the results in a small FIFO and presents them on a valid/ready stream tagged with the mode that produced them.

## Interface
Parameters:
- DATA_W, 14: sample width, two's complement.
- BLANK_CYCLES, 6: samples discarded after reset or a ctrl change; matches the filter's delay-line depth.
- FIFO_DEPTH, 8: FIFO entries, power of two, ≥2.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1: clock.
  - arst_n, in, 1: asynchronous active-low reset.
- ctrl, in, 1: filter mode, same signal that drives the filter (1 = integrator, 0 = differentiator).
- s_tdata, in, DATA_W: filter output, valid every cycle.
- dec_log2, in, 2: decimation ratio 2^dec_log2.
- m_tdata, out, DATA_W: output sample.
- m_tuser, out, 1: ctrl value in effect for the sample's window.
- m_tvalid, out, 1: output valid.
- m_tready, in, 1: downstream ready.
- overflow, out, 1: sticky flag, set when a result is dropped because the FIFO is full.
- ovf_clr, in, 1: clears overflow.

## Operation
- FSM states are BLANK and RUN.
  - Reset → BLANK, blank_cnt = BLANK_CYCLES.
  - BLANK: the sample is discarded and blank_cnt decrements. The transition is BLANK→RUN after the cycle in which blank_cnt = 1.
  - RUN→BLANK when ctrl ≠ ctrl_q (ctrl_q = ctrl registered). blank_cnt reloads, and the partial accumulation window and phase counter are discarded.
  - A ctrl change while in BLANK reloads blank_cnt.
  - The sample in the cycle where the ctrl change is detected is discarded.
- Decimator (RUN only):
  - Phase counter 0..2^dec_log2−1.
  - dec_log2 is latched at phase 0 and held for the whole window.
  - Accumulator width is DATA_W+3 and is sign-extended.
  - At the last phase, result = (acc + s_tdata) >>> dec_log2. The shift is arithmetic (floor), and the result cannot overflow DATA_W.
  - The result is registered together with the latched mode (ctrl_q) into res_q/res_vld.
- FIFO:
  - Entry is {mode, data}.
  - Push when res_vld; pop when m_tvalid && m_tready.
  - Full without pop: the new word is dropped and overflow is set.
  - Full with simultaneous pop: the push is accepted, with no overflow.
  - Empty with simultaneous push: no pop occurs.
  - Read is first-word-fall-through. m_tvalid = not empty, and m_tdata/m_tuser show the head entry.
- Overflow:
  - Set has priority over ovf_clr in the same cycle.
  - The flag stays high until cleared.

## Timing
- Reset values:
  - m_tvalid 0, m_tdata 0, m_tuser 0, overflow 0.
  - FIFO empty, state BLANK, accumulator and phase 0, res_vld 0.
  - Reset takes effect immediately with arst_n low, including mid-stream.
- Latency: with the last window sample on s_tdata in cycle c, res_vld is in c+1 and m_tvalid is in c+2 (FIFO previously empty).
- Throughput: with dec_log2 = 0, one word per clock sustained while m_tready = 1.
- First output after reset with dec_log2 = 0 is the sample presented in cycle BLANK_CYCLES, where cycle 0 is the first cycle after reset release.
- m_tdata/m_tuser are stable while m_tvalid && !m_tready.

## Structure
- Shared package adaptive_filter_pkg, additions:
  - state enum {BLANK, RUN}.
  - FIFO word struct {mode, data}.
  - Default BLANK_CYCLES derived from the filter order constant.
- Sub-module filter_out_fifo:
  - Generic synchronous FWFT FIFO.
  - Pointers one bit wider than log2(FIFO_DEPTH).
  - Outputs full/empty.
- Top level holds the FSM, decimator, overflow flag and port mapping.

## Test plan
- Reset, ctrl = 0, dec_log2 = 0, m_tready = 1, s_tdata ramp 0,1,2… → samples 0..5 dropped; first word 6 with m_tvalid in cycle 8 and m_tuser = 0; then one word per cycle.
- dec_log2 = 2 with inputs:
  - 1,2,3,4 → 2.
  - −1,−2,−3,−4 → −3.
  - 8191×4 → 8191.
  - −8192×4 → −8192.
  - One word per 4 samples.
- ctrl 0→1 at phase 2 of a dec_log2 = 2 window → partial window discarded; 6 samples blanked; next word averages the following 4 samples, m_tuser = 1.
- m_tready = 0, dec_log2 = 0, FIFO_DEPTH = 8 → 8 words buffered, 9th dropped, overflow = 1; ovf_clr in the same cycle as a further drop leaves overflow = 1; the 8 words drain in order once m_tready = 1.
- FIFO full, m_tready = 1 in the same cycle as a push → no overflow, count stays 8.
- arst_n pulsed low mid-stream with 5 words queued → m_tvalid goes 0 immediately, FIFO empty, re-blanks 6 samples after release.
